seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter BLANK_CYC, default 2: dead-time cycles at the start of each slot, range 1..SCAN_DIV-2.
REQ-004 SHALL have parameter SEG_ACT_LOW, default 1: 1 = a lit segment or dp is driven 0.
REQ-005 SHALL have parameter AN_ACT_LOW, default 1: 1 = an active anode is driven 0.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port value, input, 4*DIGITS bits: hex nibbles; nibble i = value[4i+3:4i]; digit 0 is least significant.
REQ-009 SHALL have port dp_in, input, DIGITS bits: decimal-point request per digit.
REQ-010 SHALL have port load, input, 1 bit: captures value and dp_in into the pending buffer.
REQ-011 SHALL have port blank_lz, input, 1 bit: enables leading-zero suppression.
REQ-012 SHALL have port enable, input, 1 bit: 0 blanks the display and freezes scanning.
REQ-013 SHALL have port seg, output, 7 bits: segments with bit0 = a through bit6 = g, registered.
REQ-014 SHALL have port dp, output, 1 bit: decimal point, registered.
REQ-015 SHALL have port an, output, DIGITS bits: one-hot digit anode enables, registered.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-017 SHALL implement the prescaler pcnt, counting 0..SCAN_DIV-1 while enable=1 and wrapping to 0; a terminal count is pcnt = SCAN_DIV-1.
REQ-018 SHALL implement the digit index didx, which advances on each terminal count and wraps from DIGITS-1 to 0.
REQ-019 SHALL pulse frame_done for exactly one cycle, in the cycle after didx wraps from DIGITS-1 to 0.
REQ-020 SHALL use a two-stage buffer: load=1 copies value/dp_in to pending and sets the pend flag; at the didx wrap, if pend=1, pending is copied to shadow and pend clears.
REQ-021 SHALL, when load=1 coincides with the wrap cycle, write the incoming value/dp_in directly to shadow and leave pend=0; the display SHALL never show a mix of old and new nibbles within a frame.
REQ-022 SHALL, on back-to-back loads before a wrap, let the last load win.
REQ-023 SHALL decode the active shadow nibble in active-low form as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 SHALL invert the decoded segment value when SEG_ACT_LOW=0.
REQ-025 SHALL, with blank_lz=1, treat digit i (i>0) as blank when nibbles DIGITS-1 down to i of shadow are all zero.
REQ-026 SHALL never blank digit 0 through leading-zero suppression.
REQ-027 SHALL drive a blank digit with all segments off; the dp of a blank digit still follows the shadow dp bit.
REQ-028 SHALL drive all anodes inactive while pcnt < BLANK_CYC (ghosting guard).
REQ-029 SHALL, while pcnt >= BLANK_CYC, drive only an[didx] active and drive seg/dp for digit didx.
REQ-030 SHALL register seg, dp and an one cycle after the pcnt/didx state they reflect.
REQ-031 SHALL, on enable=0, hold pcnt and didx and drive all anodes inactive and seg/dp off from the next cycle.
REQ-032 SHALL, while enable=0, keep accepting load into pending; no transfer to shadow occurs during this time.
REQ-033 SHALL, on enable returning to 1, resume from the held pcnt and didx.

Reset
REQ-034 SHALL, on rst_n=0 asynchronously, clear pcnt, didx, pending, shadow, pend and frame_done to 0.
REQ-035 SHALL, on rst_n=0, drive all of an inactive and seg/dp off at their configured polarities.
REQ-036 SHALL, on reset asserted mid-frame or mid-load, discard the pending data.
REQ-037 SHALL begin scanning after rst_n deasserts at the first rising clk edge, with pcnt=0 and didx=0.

Verification (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low)
REQ-038 SHALL cover reset-to-scan: release rst_n with enable=1, value=0 -> an=1111 in each slot's first cycle, then 1110/1101/1011/0111 for 3 cycles each, and frame_done pulses every 16 cycles.
REQ-039 SHALL cover load and decode: load value=16'h3A0F mid-frame -> no change until the wrap; next frame seg = 0001110, 1000000, 0001000, 0110000 for digits 0..3.
REQ-040 SHALL cover leading-zero blanking: blank_lz=1, value=16'h0005 -> digits 3..1 seg=1111111 with their anodes still scanned; digit 0 seg=0010010. Then value=0 -> only digit 0 shows 1000000.
REQ-041 SHALL cover load at the wrap: load=1 in the wrap cycle with value=16'h1234 -> the frame that starts immediately shows 4,3,2,1 and pend=0.
REQ-042 SHALL cover enable freeze: drop enable during the digit-2 slot for 10 cycles -> an=1111 and seg=1111111 throughout; on restore, digit 2 resumes at the held pcnt.
REQ-043 SHALL cover asynchronous reset: assert rst_n=0 between clock edges mid-frame -> an=1111 and seg=1111111 immediately, shadow=0, and a previously loaded pending value is lost.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered hex digits,
// leading-zero suppression and a blanking guard at each slot start.
// Ports: clk, rst_n (async, active low), value/dp_in/load (digit data),
//   blank_lz (suppress leading zeros), enable (0 = blank and freeze),
//   seg/dp/an (registered display drive), frame_done (end-of-frame pulse).
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int SCAN_DIV    = 50000,
   parameter int BLANK_CYC   = 2,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic                  enable,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DIGITS);

   localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
   localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

   localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7f : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACT_LOW != 0);
   localparam logic [DIGITS-1:0] AN_OFF =
      (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [PW-1:0]         pcnt;
   logic [DW-1:0]         didx;
   logic [4*DIGITS-1:0]   pending;
   logic [DIGITS-1:0]     pending_dp;
   logic                  pend;
   logic [4*DIGITS-1:0]   shadow;
   logic [DIGITS-1:0]     shadow_dp;

   logic                  tc;
   logic                  wrap;

   assign tc   = enable && (pcnt == P_LAST);
   assign wrap = tc && (didx == D_LAST);

   // Slot prescaler and digit index; both hold while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
         didx <= '0;
      end else if (enable) begin
         if (pcnt == P_LAST) begin
            pcnt <= '0;
            didx <= (didx == D_LAST) ? '0 : didx + 1'b1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

   // Two-stage buffer: shadow only changes at the frame boundary so a
   // frame never mixes old and new digits. A load landing exactly on
   // the boundary bypasses pending and goes straight to shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         pending_dp <= '0;
         pend       <= 1'b0;
         shadow     <= '0;
         shadow_dp  <= '0;
      end else if (wrap) begin
         pend <= 1'b0;
         if (load) begin
            shadow    <= value;
            shadow_dp <= dp_in;
         end else if (pend) begin
            shadow    <= pending;
            shadow_dp <= pending_dp;
         end
      end else if (load) begin
         pending    <= value;
         pending_dp <= dp_in;
         pend       <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_done <= 1'b0;
      else        frame_done <= wrap;
   end

   logic [4*DIGITS-1:0]   lead;
   logic [3:0]            nib;
   logic                  lz_blank;
   logic [6:0]            font;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt;
   logic [DIGITS-1:0]     an_hot;
   logic [DIGITS-1:0]     an_nxt;
   logic                  show;

   always_comb begin
      // Shadow shifted down to the current digit: its low nibble is the
      // digit, and all-zero means this digit and above are zeros.
      lead     = shadow >> {didx, 2'b00};
      nib      = lead[3:0];
      lz_blank = blank_lz && (didx != '0) && (lead == '0);
      font     = 7'h7f;
      unique case (nib)
         4'h0: font = 7'b1000000;
         4'h1: font = 7'b1111001;
         4'h2: font = 7'b0100100;
         4'h3: font = 7'b0110000;
         4'h4: font = 7'b0011001;
         4'h5: font = 7'b0010010;
         4'h6: font = 7'b0000010;
         4'h7: font = 7'b1111000;
         4'h8: font = 7'b0000000;
         4'h9: font = 7'b0010000;
         4'ha: font = 7'b0001000;
         4'hb: font = 7'b0000011;
         4'hc: font = 7'b1000110;
         4'hd: font = 7'b0100001;
         4'he: font = 7'b0000110;
         4'hf: font = 7'b0001110;
      endcase
      if (lz_blank) font = 7'h7f;
      seg_nxt = (SEG_ACT_LOW != 0) ? font : ~font;
      an_hot  = DIGITS'(1) << didx;
      dp_nxt  = (SEG_ACT_LOW != 0) ? ~(|(shadow_dp & an_hot))
                                   : |(shadow_dp & an_hot);
      an_nxt  = (AN_ACT_LOW != 0) ? ~an_hot : an_hot;
      // Anodes stay dark for the first BLANK_CYC cycles of each slot.
      show    = enable && (pcnt >= P_BLANK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         dp  <= DP_OFF;
         an  <= AN_OFF;
      end else if (show) begin
         seg <= seg_nxt;
         dp  <= dp_nxt;
         an  <= an_nxt;
      end else begin
         seg <= SEG_OFF;
         dp  <= DP_OFF;
         an  <= AN_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots,
// 1 blank cycle, active-low): frame-position model feeds a queue.
module tb_seg7_scan_driver;

   localparam int DIGITS = 4;
   localparam int SD     = 4;
   localparam int BC     = 1;
   localparam int N      = DIGITS * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic        enable = 1'b1;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   seg7_scan_driver #(
      .DIGITS(DIGITS), .SCAN_DIV(SD), .BLANK_CYC(BC),
      .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
      .load(load), .blank_lz(blank_lz), .enable(enable),
      .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int passed = 0;

   logic [6:0] fnt [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model state: position within the frame, displayed and pending data.
   int          mt = 0;
   logic [15:0] m_shadow = '0;
   logic [15:0] m_pend = '0;
   logic [3:0]  m_sdp = '0;
   logic [3:0]  m_pdp = '0;
   bit          m_pendf = 0;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h at %0t",
                    nm, act, exp, $time);
   endtask

   function automatic exp_t view();
      exp_t e;
      int d;
      int p;
      logic [15:0] top;
      d = mt / SD;
      p = mt % SD;
      e.fd = 1'b0;
      if (!enable || p < BC) begin
         e.an  = 4'hf;
         e.seg = 7'h7f;
         e.dp  = 1'b1;
      end else begin
         top   = m_shadow >> (4 * d);
         e.an  = ~(4'b0001 << d);
         e.seg = (blank_lz && d > 0 && top == 0) ? 7'h7f
                                                 : fnt[top[3:0]];
         e.dp  = ~m_sdp[d];
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      bit   wr;
      if (!rst_n) begin
         mt = 0;
         m_shadow = '0;
         m_pend = '0;
         m_sdp = '0;
         m_pdp = '0;
         m_pendf = 0;
         q.delete();
      end else begin
         e = view();
         wr = enable && (mt == N - 1);
         e.fd = wr;
         q.push_back(e);
         if (wr) begin
            if (load) begin
               m_shadow = value;
               m_sdp = dp_in;
            end else if (m_pendf) begin
               m_shadow = m_pend;
               m_sdp = m_pdp;
            end
            m_pendf = 0;
         end else if (load) begin
            m_pend = value;
            m_pdp = dp_in;
            m_pendf = 1;
         end
         if (enable) mt = (mt + 1) % N;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("rst_an", an, 4'hf);
         chk("rst_seg", seg, 7'h7f);
         chk("rst_dp", dp, 1);
         chk("rst_fd", frame_done, 0);
      end else if (q.size() > 0) begin
         e = q.pop_front();
         chk("an", an, e.an);
         chk("seg", seg, e.seg);
         chk("dp", dp, e.dp);
         chk("frame_done", frame_done, e.fd);
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_t(int target);
      int k = 0;
      while (mt != target && k < 2 * N) begin
         tick();
         k++;
      end
      chk("sync", mt, target);
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(40);

      wait_t(5);
      value = 16'h3a0f;
      dp_in = 4'b0100;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick(40);

      blank_lz = 1'b1;
      value = 16'h0005;
      dp_in = 4'b0000;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick(36);
      value = 16'h0000;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick(36);
      blank_lz = 1'b0;

      wait_t(N - 1);
      value = 16'h1234;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick(20);

      wait_t(2 * SD + 2);
      enable = 1'b0;
      tick(10);
      enable = 1'b1;
      tick(20);

      for (int i = 0; i < 300; i++) begin
         value = 16'($urandom);
         dp_in = 4'($urandom);
         load = ($urandom_range(0, 7) == 0);
         blank_lz = 1'($urandom);
         enable = ($urandom_range(0, 9) != 0);
         tick();
      end
      load = 1'b0;
      enable = 1'b1;
      blank_lz = 1'b0;

      wait_t(6);
      value = 16'hbeef;
      dp_in = 4'b1111;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("async_an", an, 4'hf);
      chk("async_seg", seg, 7'h7f);
      tick(3);
      rst_n = 1'b1;
      tick(40);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
